// File: rtl/alarm_pkg.sv
// alarm_pkg: shared slot state, BCD time layout and validity check for the alarm bank
package alarm_pkg;
    typedef enum logic [1:0] {OFF, ARMED, RINGING, SNOOZED} slot_state_e;
    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;
    function automatic logic bcd_valid(bcd_time_t t);
        return t.mt <= 4'd5 && t.mo <= 4'd9 && t.st <= 4'd5 && t.so <= 4'd9;
    endfunction
endpackage

// File: rtl/alarm_slot.sv
// alarm_slot: one alarm slot's state machine, stored time and ring/snooze down-counter
module alarm_slot
    import alarm_pkg::*;
#(
    parameter int RING_SEC = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [15:0] wr_time_i,
    input  logic        wr_arm_i,
    input  logic        snooze_i,
    input  logic        dismiss_i,
    input  logic        sec_strb_i,
    input  logic        trig_i,
    input  logic [15:0] cur_time_i,
    output logic [15:0] time_o,
    output logic        armed_o,
    output logic        ring_o
);
    localparam int CW = $clog2((RING_SEC > SNOOZE_SEC ? RING_SEC : SNOOZE_SEC) + 1);
    localparam logic [CW-1:0] RING_CNT = CW'(RING_SEC);
    localparam logic [CW-1:0] SNZ_CNT = CW'(SNOOZE_SEC);
    slot_state_e state_q, state_d;
    bcd_time_t tm_q, tm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic active;
    assign active = state_q == RINGING || state_q == SNOOZED;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            tm_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            tm_q <= tm_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        tm_d = tm_q;
        cnt_d = cnt_q;
        if (wr_en_i) begin
            tm_d = wr_time_i;
            state_d = wr_arm_i ? ARMED : OFF;
            cnt_d = '0;
        end else if (dismiss_i && active) begin
            state_d = ARMED;
            cnt_d = '0;
        end else if (snooze_i && state_q == RINGING) begin
            state_d = SNOOZED;
            cnt_d = SNZ_CNT;
        end else if (state_q == ARMED && trig_i && bcd_valid(tm_q) && tm_q == cur_time_i) begin
            state_d = RINGING;
            cnt_d = RING_CNT;
        end else if (sec_strb_i && active) begin
            // expiry: a ring falls back to armed, a snooze resumes ringing
            if (cnt_q == CW'(1)) begin
                state_d = state_q == RINGING ? ARMED : RINGING;
                cnt_d = state_q == RINGING ? '0 : RING_CNT;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end
    assign time_o = tm_q;
    assign armed_o = state_q != OFF;
    assign ring_o = state_q == RINGING;
endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS alarm slots compared against the MM:SS BCD clock once per second,
// with ring mask, lowest ringing index, readback and a blink gate for the display enables.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC = 60,
    parameter int SNOOZE_SEC = 300,
    localparam int IW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sec_strb,
    input  logic                  i_half_pulse,
    input  logic                  i_run,
    input  logic [15:0]           i_time,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [15:0]           wr_time,
    input  logic                  wr_arm,
    input  logic                  cmd_snooze,
    input  logic                  cmd_dismiss,
    input  logic [IW-1:0]         rd_idx,
    output logic [15:0]           o_rd_time,
    output logic [NUM_ALARMS-1:0] o_armed_mask,
    output logic [NUM_ALARMS-1:0] o_ring_mask,
    output logic                  o_ringing,
    output logic [IW-1:0]         o_ring_idx,
    output logic                  o_flash
);
    // compare one cycle after the strobe so i_time already holds the new second
    logic cmp_tick_q;
    logic [15:0] slot_time [NUM_ALARMS];
    always_ff @(posedge clk) begin
        if (rst) cmp_tick_q <= 1'b0;
        else cmp_tick_q <= i_sec_strb;
    end
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        alarm_slot #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en && wr_idx == IW'(g)),
            .wr_time_i (wr_time),
            .wr_arm_i  (wr_arm),
            .snooze_i  (cmd_snooze),
            .dismiss_i (cmd_dismiss),
            .sec_strb_i(i_sec_strb),
            .trig_i    (cmp_tick_q && i_run),
            .cur_time_i(i_time),
            .time_o    (slot_time[g]),
            .armed_o   (o_armed_mask[g]),
            .ring_o    (o_ring_mask[g])
        );
    end
    always_comb begin
        o_ring_idx = '0;
        o_rd_time = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (o_ring_mask[i]) o_ring_idx = IW'(i);
            if (rd_idx == IW'(i)) o_rd_time = slot_time[i];
        end
    end
    assign o_ringing = |o_ring_mask;
    assign o_flash = o_ringing ? i_half_pulse : 1'b1;
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: table-driven writes, hand-written alarm sequences and a randomized run
// checked against a deadline-based reference model.
module tb_alarm_bank;
    localparam int N = 4;
    localparam int RS = 3;
    localparam int SS = 2;
    logic clk = 0, rst = 1;
    logic i_sec_strb = 0, i_half_pulse = 0, i_run = 1;
    logic [15:0] i_time = 0;
    logic wr_en = 0, wr_arm = 0, cmd_snooze = 0, cmd_dismiss = 0;
    logic [1:0] wr_idx = 0, rd_idx = 0;
    logic [15:0] wr_time = 0;
    logic [15:0] o_rd_time;
    logic [N-1:0] o_armed_mask, o_ring_mask;
    logic o_ringing, o_flash;
    logic [1:0] o_ring_idx;
    int n_chk = 0, n_pass = 0;

    alarm_bank #(.NUM_ALARMS(N), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .clk(clk), .rst(rst), .i_sec_strb(i_sec_strb), .i_half_pulse(i_half_pulse),
        .i_run(i_run), .i_time(i_time), .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time),
        .wr_arm(wr_arm), .cmd_snooze(cmd_snooze), .cmd_dismiss(cmd_dismiss), .rd_idx(rd_idx),
        .o_rd_time(o_rd_time), .o_armed_mask(o_armed_mask), .o_ring_mask(o_ring_mask),
        .o_ringing(o_ringing), .o_ring_idx(o_ring_idx), .o_flash(o_flash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] t, input logic arm);
        wr_en = 1; wr_idx = idx; wr_time = t; wr_arm = arm;
        tick();
        wr_en = 0;
    endtask

    task automatic sec(input logic [15:0] t);
        i_time = t; i_sec_strb = 1;
        tick();
        i_sec_strb = 0;
        tick();
        tick();
    endtask

    task automatic pulse(input logic snz, input logic dis);
        cmd_snooze = snz; cmd_dismiss = dis;
        tick();
        cmd_snooze = 0; cmd_dismiss = 0;
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] tm;
        logic        arm;
        logic [3:0]  armed;
    } wv_t;
    wv_t tv[6];
    logic [15:0] rb_exp[4];

    // reference model: 0 off, 1 armed, 2 ringing, 3 snoozed; expiry as an absolute strobe count
    int md[N];
    logic [15:0] mt[N];
    int dl[N];
    int nsec;
    logic prev_strb;
    logic [15:0] tpool[4];

    function automatic bit good_bcd(logic [15:0] t);
        int v = int'(t);
        return (v / 4096) % 16 < 6 && (v / 256) % 16 < 10 && (v / 16) % 16 < 6 && v % 16 < 10;
    endfunction

    initial begin
        tv[0] = '{2'd0, 16'h1234, 1'b1, 4'b0001};
        tv[1] = '{2'd1, 16'h5959, 1'b1, 4'b0011};
        tv[2] = '{2'd2, 16'h0A00, 1'b1, 4'b0111};
        tv[3] = '{2'd3, 16'h0000, 1'b0, 4'b0111};
        tv[4] = '{2'd1, 16'h0001, 1'b0, 4'b0101};
        tv[5] = '{2'd0, 16'hFFFF, 1'b0, 4'b0100};
        rb_exp = '{16'hFFFF, 16'h0001, 16'h0A00, 16'h0000};
        tpool = '{16'h0010, 16'h0011, 16'h0A00, 16'h0012};
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            wr(tv[i].idx, tv[i].tm, tv[i].arm);
            rd_idx = tv[i].idx;
            #1;
            chk("tbl_rd_time", o_rd_time, tv[i].tm);
            chk("tbl_armed", o_armed_mask, tv[i].armed);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("tbl_readback", o_rd_time, rb_exp[i]);
        end

        rst = 1; tick(); rst = 0;
        chk("rst_ring", o_ring_mask, 0);
        chk("rst_armed", o_armed_mask, 0);
        chk("rst_idx", o_ring_idx, 0);
        chk("rst_flash", o_flash, 1);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("rst_rd_time", o_rd_time, 0);
        end

        wr(2, 16'h0105, 1);
        sec(16'h0103);
        sec(16'h0104);
        i_time = 16'h0105; i_sec_strb = 1;
        tick();
        i_sec_strb = 0;
        chk("t1_lat_t1", o_ring_mask, 0);
        tick();
        chk("t1_ring", o_ring_mask, 4'b0100);
        chk("t1_idx", o_ring_idx, 2);
        i_half_pulse = 1; #1;
        chk("t1_flash_hi", o_flash, 1);
        i_half_pulse = 0; #1;
        chk("t1_flash_lo", o_flash, 0);
        sec(16'h0106);
        sec(16'h0107);
        chk("t1_still_ring", o_ring_mask, 4'b0100);
        sec(16'h0108);
        chk("t1_auto_off", o_ring_mask, 0);
        chk("t1_rearmed", o_armed_mask, 4'b0100);

        wr(0, 16'h0200, 1);
        sec(16'h0200);
        chk("t2_ring", o_ring_mask, 4'b0001);
        pulse(1, 0);
        chk("t2_snoozed", o_ring_mask, 0);
        chk("t2_armed", o_armed_mask, 4'b0101);
        chk("t2_flash", o_flash, 1);
        sec(16'h0201);
        chk("t2_snz1", o_ring_mask, 0);
        sec(16'h0202);
        chk("t2_reraise", o_ring_mask, 4'b0001);
        pulse(0, 1);
        chk("t2_dismiss", o_ringing, 0);
        chk("t2_dis_armed", o_armed_mask, 4'b0101);

        wr(0, 16'h0000, 0);
        wr(2, 16'h0000, 0);
        wr(1, 16'h0010, 1);
        wr(3, 16'h0010, 1);
        sec(16'h0010);
        chk("t3_ring", o_ring_mask, 4'b1010);
        chk("t3_idx", o_ring_idx, 1);
        pulse(0, 1);
        chk("t3_dismiss", o_ring_mask, 0);
        chk("t3_armed", o_armed_mask, 4'b1010);

        sec(16'h0010);
        chk("t4_ring", o_ring_mask, 4'b1010);
        pulse(1, 1);
        chk("t4_both", o_ring_mask, 0);
        sec(16'h0011);
        sec(16'h0012);
        chk("t4_not_snoozed", o_ring_mask, 0);

        i_run = 0;
        sec(16'h0010);
        chk("t5_frozen", o_ring_mask, 0);
        i_run = 1;
        wr(0, 16'h0A00, 1);
        sec(16'h0A00);
        chk("t5_invalid", o_ring_mask, 0);
        chk("t5_inv_armed", o_armed_mask, 4'b1011);

        i_time = 16'h0010; i_sec_strb = 1;
        tick();
        i_sec_strb = 0;
        wr(1, 16'h0010, 1);
        chk("wr_vs_tick", o_ring_mask, 4'b1000);
        chk("wr_vs_idx", o_ring_idx, 3);
        tick();
        chk("wr_vs_hold", o_ring_mask, 4'b1000);

        i_half_pulse = 0;
        rst = 1; tick();
        chk("t6_ring", o_ring_mask, 0);
        chk("t6_armed", o_armed_mask, 0);
        chk("t6_ringing", o_ringing, 0);
        chk("t6_flash", o_flash, 1);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("t6_rd_time", o_rd_time, 0);
        end
        rst = 0;

        for (int s = 0; s < N; s++) begin
            md[s] = 0; mt[s] = 0; dl[s] = 0;
        end
        nsec = 0;
        prev_strb = 0;
        for (int c = 0; c < 800; c++) begin
            int nsn;
            int lo;
            logic [3:0] er, ea;
            i_sec_strb = $urandom_range(0, 2) == 0;
            i_half_pulse = 1'($urandom);
            i_run = $urandom_range(0, 7) != 0;
            i_time = tpool[$urandom_range(0, 3)];
            wr_en = $urandom_range(0, 11) == 0;
            wr_idx = 2'($urandom);
            wr_time = tpool[$urandom_range(0, 3)];
            wr_arm = $urandom_range(0, 3) != 0;
            cmd_snooze = $urandom_range(0, 14) == 0;
            cmd_dismiss = $urandom_range(0, 19) == 0;
            rd_idx = 2'($urandom);
            nsn = nsec + (i_sec_strb ? 1 : 0);
            for (int s = 0; s < N; s++) begin
                if (wr_en && int'(wr_idx) == s) begin
                    mt[s] = wr_time;
                    md[s] = wr_arm ? 1 : 0;
                end else if (cmd_dismiss && md[s] >= 2) begin
                    md[s] = 1;
                end else if (cmd_snooze && md[s] == 2) begin
                    md[s] = 3;
                    dl[s] = nsn + SS;
                end else if (md[s] == 1 && prev_strb && i_run && good_bcd(mt[s]) && mt[s] == i_time) begin
                    md[s] = 2;
                    dl[s] = nsn + RS;
                end else if (i_sec_strb && md[s] >= 2 && nsn == dl[s]) begin
                    md[s] = md[s] == 2 ? 1 : 2;
                    dl[s] = nsn + RS;
                end
            end
            nsec = nsn;
            prev_strb = i_sec_strb;
            tick();
            er = 0; ea = 0; lo = 0;
            for (int s = N - 1; s >= 0; s--) begin
                er[s] = md[s] == 2;
                ea[s] = md[s] != 0;
                if (md[s] == 2) lo = s;
            end
            chk("rnd_ring", o_ring_mask, er);
            chk("rnd_armed", o_armed_mask, ea);
            chk("rnd_idx", o_ring_idx, lo);
            chk("rnd_flash", o_flash, er != 0 ? i_half_pulse : 1'b1);
            chk("rnd_rd_time", o_rd_time, mt[rd_idx]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-alarm engine for the MM:SS BCD clock datapath: holds NUM_ALARMS independently armed alarm times and compares them against the running clock once per second. Each slot supports ringing with auto-timeout, snooze and dismiss. Outputs are a ring mask, the index of the ringing slot, and a blink gate for the 7-segment enables. Sits beside the clock datapath and UART command decoder in the top level; it replaces the single inline alarm comparator.

## Interface
- NUM_ALARMS, 4, number of alarm slots (1..16)
- RING_SEC, 60, seconds a slot rings before auto-dismiss (1..3599)
- SNOOZE_SEC, 300, seconds a snoozed slot stays silent (1..3599)
- clk  in  1  system clock (12 MHz)
- rst  in  1  reset, synchronous, active-high; clock clk
- i_sec_strb  in  1  one-cycle strobe per second; clock digits update on this edge
- i_half_pulse  in  1  0.5 s high / 0.5 s low square wave
- i_run  in  1  1: clock running; 0: frozen, triggers suppressed
- i_time  in  16  current time BCD {Mtens,Mones,Stens,Sones}
- wr_en  in  1  write slot wr_idx this cycle
- wr_idx  in  IW=max(1,$clog2(NUM_ALARMS))  slot to write
- wr_time  in  16  alarm time BCD, same packing as i_time
- wr_arm  in  1  with wr_en: 1 arms slot, 0 turns it off
- cmd_snooze  in  1  one-cycle pulse: snooze all RINGING slots
- cmd_dismiss  in  1  one-cycle pulse: dismiss all RINGING/SNOOZED slots
- rd_idx  in  IW  readback select
- o_rd_time  out  16  stored time of slot rd_idx (combinational)
- o_armed_mask  out  NUM_ALARMS  slot state != OFF
- o_ring_mask  out  NUM_ALARMS  slot state == RINGING
- o_ringing  out  1  OR of o_ring_mask
- o_ring_idx  out  IW  lowest-index ringing slot; 0 when none
- o_flash  out  1  display enable gate: 1 when not ringing, else i_half_pulse

## Operation
- Per-slot state: OFF, ARMED, RINGING, SNOOZED; per-slot 16-bit time and down-counter of width CW=$clog2(max(RING_SEC,SNOOZE_SEC)+1).
- cmp_tick = i_sec_strb registered one cycle (samples updated i_time).
- Write: wr_en sets time[wr_idx]=wr_time, state = wr_arm ? ARMED : OFF, counter 0. Overrides any state, including RINGING.
- ARMED: cmp_tick & i_run & time==i_time -> RINGING, counter=RING_SEC.
- RINGING: cmd_dismiss -> ARMED; else cmd_snooze -> SNOOZED, counter=SNOOZE_SEC; else on i_sec_strb decrement; decrementing from 1 -> ARMED (auto-dismiss).
- SNOOZED: cmd_dismiss -> ARMED; on i_sec_strb decrement; from 1 -> RINGING, counter=RING_SEC.
- Priority per slot: write > dismiss > snooze > trigger/count.
- Multiple slots may ring simultaneously; commands apply to all eligible slots.
- Invalid BCD (digit > 9, or Mtens/Stens > 5) is stored verbatim; it never matches.
- i_run=0 suppresses only triggers; snooze and ring counters keep counting.

## Timing
- Reset: all slots OFF, times 16'h0000, counters 0; o_*_mask=0, o_ringing=0, o_ring_idx=0, o_flash=1, o_rd_time=0.
- State, time and counter are registered. All o_* are combinational from registers plus i_half_pulse/rd_idx.
- Trigger latency: i_time becomes equal to slot time at strobe cycle T; o_ring_mask bit rises at T+2.
- Writes and commands are visible on outputs the cycle after assertion.
- Ring duration: exactly RING_SEC strobes after the trigger strobe. Snooze: exactly SNOOZE_SEC strobes.
- A write at cycle T plus a cmp_tick matching at T: the write wins, and no trigger occurs that second.
- rst asserted mid-ring: all slots return to OFF next cycle.

## Structure
- Package alarm_pkg: slot state enum (OFF/ARMED/RINGING/SNOOZED), bcd_time_t (16-bit packed), and function bcd_valid.
- Sub-module alarm_slot: one slot's state machine, time register and counter. Instantiated NUM_ALARMS times in a generate loop. The top holds cmp_tick, the priority encoder for o_ring_idx, the readback mux and o_flash.

## Test plan
- Arm slot 2 at 01:05 with RING_SEC=3 and run the clock from 01:03 -> ring_mask=4'b0100 at strobe(01:05)+2 cycles, o_ring_idx=2, o_flash follows i_half_pulse. Returns to ARMED after 3 strobes.
- Ringing slot 0, cmd_snooze, SNOOZE_SEC=2 -> SNOOZED, o_flash=1. Rings again after 2 strobes. cmd_dismiss -> ARMED, o_ringing=0.
- Slots 1 and 3 both set to 00:10 -> ring_mask=4'b1010, o_ring_idx=1. A single cmd_dismiss clears both.
- cmd_snooze and cmd_dismiss in the same cycle -> slot goes to ARMED, not SNOOZED.
- i_run=0 while time passes 00:10 (manually loaded) -> no trigger. wr_time=16'h0A00 (invalid) -> never rings.
- rst during RINGING -> all masks 0 and o_flash=1 next cycle. o_rd_time for every slot reads 16'h0000.
